// File: rtl/alu_io_sequencer.sv
// Byte-serial command sequencer between a host handshake and a multi-cycle ALU.
// Optional WAIT_END timeout abort is enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_io_sequencer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_x,
   input  logic [7:0]  cmd_y,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic        res_err,
   output logic        busy,
   output logic        alu_begin,
   output logic [1:0]  alu_op_code,
   output logic [7:0]  alu_inbus,
   input  logic [7:0]  alu_outbus,
   input  logic        alu_end
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] START    = 3'd1;
   localparam logic [2:0] LOAD0    = 3'd2;
   localparam logic [2:0] LOAD1    = 3'd3;
   localparam logic [2:0] LOAD2    = 3'd4;
   localparam logic [2:0] WAIT_END = 3'd5;
   localparam logic [2:0] CAPT_LO  = 3'd6;
   localparam logic [2:0] RESP     = 3'd7;

   logic [2:0]  state;
   logic [1:0]  op_q;
   logic [15:0] x_q;
   logic [7:0]  y_q;
   logic [15:0] data_q;
   logic        is_div;
   logic        tmo_hit;

   assign is_div = (op_q == 2'b11);

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] tmo_cnt;
   logic          err_q;

   // Counter restarts on every WAIT_END visit; it idles at zero elsewhere.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (state != WAIT_END) begin
         tmo_cnt <= '0;
      end else if (!alu_end) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign tmo_hit = (state == WAIT_END) && !alu_end &&
                    (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign res_err = err_q;
`else
   assign tmo_hit = 1'b0;
   assign res_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         op_q   <= '0;
         x_q    <= '0;
         y_q    <= '0;
         data_q <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
         err_q  <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_q  <= cmd_op;
                  x_q   <= cmd_x;
                  y_q   <= cmd_y;
                  state <= START;
`ifdef ALU_SEQ_TIMEOUT_EN
                  err_q <= 1'b0;
`endif
               end
            end
            START: state <= LOAD0;
            LOAD0: state <= LOAD1;
            LOAD1: state <= is_div ? LOAD2 : WAIT_END;
            LOAD2: state <= WAIT_END;
            WAIT_END: begin
               if (alu_end) begin
                  data_q[15:8] <= alu_outbus;
                  state        <= CAPT_LO;
               end else if (tmo_hit) begin
                  data_q <= 16'hFFFF;
                  state  <= RESP;
`ifdef ALU_SEQ_TIMEOUT_EN
                  err_q  <= 1'b1;
`endif
               end
            end
            CAPT_LO: begin
               data_q[7:0] <= alu_outbus;
               state       <= RESP;
            end
            RESP: begin
               if (res_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Operand byte order: div sends X high, X low, Y; others X low, Y.
   always_comb begin
      alu_inbus = '0;
      unique case (state)
         LOAD0:   alu_inbus = is_div ? x_q[15:8] : x_q[7:0];
         LOAD1:   alu_inbus = is_div ? x_q[7:0]  : y_q;
         LOAD2:   alu_inbus = y_q;
         default: alu_inbus = '0;
      endcase
   end

   assign cmd_ready   = (state == IDLE);
   assign busy        = (state != IDLE);
   assign alu_begin   = (state == START);
   assign res_valid   = (state == RESP);
   assign alu_op_code = op_q;
   assign res_data    = data_q;

endmodule

// File: tb/tb_alu_io_sequencer.sv
// Directed bench for alu_io_sequencer: byte sequencing, latency,
// backpressure, mid-operation reset and (if enabled) WAIT_END timeout.
module tb_alu_io_sequencer;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_x;
   logic [7:0]  cmd_y;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        res_err;
   logic        busy;
   logic        alu_begin;
   logic [1:0]  alu_op_code;
   logic [7:0]  alu_inbus;
   logic [7:0]  alu_outbus;
   logic        alu_end;

   int n_cmp;
   int n_bad;

   alu_io_sequencer #(.TIMEOUT_CYCLES(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_x      (cmd_x),
      .cmd_y      (cmd_y),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_err    (res_err),
      .busy       (busy),
      .alu_begin  (alu_begin),
      .alu_op_code(alu_op_code),
      .alu_inbus  (alu_inbus),
      .alu_outbus (alu_outbus),
      .alu_end    (alu_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_res_err"}, 32'(res_err), 32'd0);
      chk({tag, "_res_data"}, 32'(res_data), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_begin"}, 32'(alu_begin), 32'd0);
      chk({tag, "_op_code"}, 32'(alu_op_code), 32'd0);
      chk({tag, "_inbus"}, 32'(alu_inbus), 32'd0);
   endtask

   // Runs one command up to RESP; n = WAIT_END cycles incl. the alu_end one.
   task automatic run_cmd(input string nm, input logic [1:0] op,
                          input logic [15:0] x, input logic [7:0] y,
                          input logic [7:0] hi, input logic [7:0] lo,
                          input int n, input bit spur);
      int lat;
      bit dv;
      dv = (op == 2'b11);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_x     = x;
      cmd_y     = y;
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 0;
      chk({nm, "_start_begin"}, 32'(alu_begin), 32'd1);
      chk({nm, "_start_inbus"}, 32'(alu_inbus), 32'd0);
      chk({nm, "_start_ready"}, 32'(cmd_ready), 32'd0);
      @(negedge clk);
      lat++;
      chk({nm, "_load0_begin"}, 32'(alu_begin), 32'd0);
      chk({nm, "_load0_inbus"}, 32'(alu_inbus),
          32'(dv ? x[15:8] : x[7:0]));
      chk({nm, "_op_code"}, 32'(alu_op_code), 32'(op));
      @(negedge clk);
      lat++;
      chk({nm, "_load1_inbus"}, 32'(alu_inbus), 32'(dv ? x[7:0] : y));
      if (spur) begin
         alu_end    = 1'b1;
         alu_outbus = 8'hEE;
      end
      if (dv) begin
         @(negedge clk);
         lat++;
         alu_end = 1'b0;
         chk({nm, "_load2_inbus"}, 32'(alu_inbus), 32'(y));
      end
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         lat++;
         chk({nm, "_wait_inbus"}, 32'(alu_inbus), 32'd0);
         alu_end    = (i == n - 1);
         alu_outbus = (i == n - 1) ? hi : 8'h00;
      end
      @(negedge clk);
      lat++;
      alu_end    = 1'b0;
      alu_outbus = lo;
      chk({nm, "_capt_valid"}, 32'(res_valid), 32'd0);
      @(negedge clk);
      lat++;
      alu_outbus = 8'h00;
      chk({nm, "_res_valid"}, 32'(res_valid), 32'd1);
      chk({nm, "_res_data"}, 32'(res_data), 32'({hi, lo}));
      chk({nm, "_res_err"}, 32'(res_err), 32'd0);
      chk({nm, "_latency"}, 32'(lat), 32'((dv ? 5 : 4) + n));
   endtask

   task automatic accept_res(input string nm);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({nm, "_done_valid"}, 32'(res_valid), 32'd0);
      chk({nm, "_done_ready"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = 2'b00;
      cmd_x      = 16'h0000;
      cmd_y      = 8'h00;
      res_ready  = 1'b1;
      alu_outbus = 8'h00;
      alu_end    = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outs("rst");
      reset = 1'b0;
      @(negedge clk);
      // Stray res_ready and alu_end while idle must do nothing.
      alu_end = 1'b1;
      @(negedge clk);
      alu_end   = 1'b0;
      res_ready = 1'b0;
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(res_valid), 32'd0);

      run_cmd("add", 2'b00, 16'h0012, 8'h34, 8'h46, 8'h00, 3, 1'b0);
      accept_res("add");
      run_cmd("div", 2'b11, 16'h1234, 8'h56, 8'h0A, 8'h36, 2, 1'b0);
      accept_res("div");
      run_cmd("sub_spur", 2'b01, 16'hFF77, 8'h22, 8'h55, 8'h01, 1, 1'b1);
      accept_res("sub_spur");

      // Backpressure: held result, second command ignored.
      run_cmd("mul_bp", 2'b10, 16'h00AB, 8'h03, 8'h02, 8'h01, 4, 1'b0);
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_x     = 16'h0001;
      cmd_y     = 8'h01;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(res_valid), 32'd1);
         chk("bp_data", 32'(res_data), 32'h0201);
         chk("bp_ready", 32'(cmd_ready), 32'd0);
         chk("bp_begin", 32'(alu_begin), 32'd0);
      end
      cmd_valid = 1'b0;
      accept_res("bp");
      @(negedge clk);
      chk("bp_no_queue", 32'(busy), 32'd0);

      // Back-to-back: accept on the cycle right after the RESP handshake.
      run_cmd("b2b_a", 2'b00, 16'h0001, 8'h02, 8'h03, 8'h04, 1, 1'b0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("b2b_begin", 32'(alu_begin), 32'd1);
      chk("b2b_op", 32'(alu_op_code), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // Reset while in WAIT_END.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_x     = 16'h0033;
      cmd_y     = 8'h44;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("rw_busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1 chk_reset_outs("rw");
      @(negedge clk);
      reset = 1'b0;
      alu_end    = 1'b1;
      alu_outbus = 8'h99;
      @(negedge clk);
      alu_end = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rw_no_valid", 32'(res_valid), 32'd0);
         chk("rw_no_begin", 32'(alu_begin), 32'd0);
      end

`ifdef ALU_SEQ_TIMEOUT_EN
      begin
         int lat;
         bit seen;
         @(negedge clk);
         cmd_valid = 1'b1;
         cmd_op    = 2'b00;
         cmd_x     = 16'h0010;
         cmd_y     = 8'h20;
         @(negedge clk);
         cmd_valid = 1'b0;
         lat  = 0;
         seen = 1'b0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = res_valid;
         end
         chk("tmo_seen", 32'(seen), 32'd1);
         chk("tmo_latency", 32'(lat), 32'd11);
         chk("tmo_err", 32'(res_err), 32'd1);
         chk("tmo_data", 32'(res_data), 32'hFFFF);
         accept_res("tmo");
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_io_sequencer.md
ALU_IO_SEQUENCER -- requirements
Module: alu_io_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles in WAIT_END before abort (used only with ALU_SEQ_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  host command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-007 cmd_x  input  16  operand X; div uses all 16 bits (dividend), others use [7:0].
REQ-008 cmd_y  input  8  operand Y (second operand or divisor).
REQ-009 res_valid  output  1  result held for host.
REQ-010 res_ready  input  1  host accepts result.
REQ-011 res_data  output  16  {first captured byte, second captured byte}.
REQ-012 res_err  output  1  result aborted by timeout; valid only with res_valid.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 alu_begin  output  1  BEGIN pulse to ALU.
REQ-015 alu_op_code  output  2  op code to ALU, held stable from START to end of capture.
REQ-016 alu_inbus  output  8  operand byte to ALU.
REQ-017 alu_outbus  input  8  result byte from ALU.
REQ-018 alu_end  input  1  ALU END flag.

Function
REQ-019 States SHALL be IDLE, START, LOAD0, LOAD1, LOAD2, WAIT_END, CAPT_LO, RESP.
REQ-020 cmd_ready SHALL equal 1 only in IDLE; command accepted on cmd_valid&cmd_ready, latching op, X, Y into internal registers; IDLE->START.
REQ-021 START: alu_begin=1 for exactly one cycle, alu_inbus=0; ->LOAD0.
REQ-022 LOAD0: alu_inbus = div ? X[15:8] : X[7:0]; ->LOAD1.
REQ-023 LOAD1: alu_inbus = div ? X[7:0] : Y; ->LOAD2 if div, else ->WAIT_END.
REQ-024 LOAD2 (div only): alu_inbus = Y; ->WAIT_END.
REQ-025 alu_inbus SHALL be 0 in every state not listed above.
REQ-026 WAIT_END: on alu_end=1, capture alu_outbus into res_data[15:8]; ->CAPT_LO.
REQ-027 CAPT_LO: capture alu_outbus into res_data[7:0] unconditionally; ->RESP.
REQ-028 RESP: res_valid=1, res_data and res_err stable; on res_ready=1 ->IDLE next cycle; res_valid deasserts same edge.
REQ-029 res_ready while res_valid=0 SHALL be ignored; cmd_valid outside IDLE SHALL be ignored (no queuing).
REQ-030 alu_end asserted outside WAIT_END SHALL be ignored.
REQ-031 Command-to-res_valid latency SHALL be 4 + N cycles (non-div) or 5 + N (div), N = cycles spent in WAIT_END including the alu_end cycle.
REQ-032 Back-to-back: earliest next acceptance SHALL be the cycle after the RESP handshake.

Reset
REQ-033 On reset=1, immediately: state IDLE, cmd_ready=1 after release, res_valid=0, res_err=0, res_data=0, busy=0, alu_begin=0, alu_op_code=0, alu_inbus=0, timeout counter=0.
REQ-034 Reset mid-operation SHALL abandon the command with no result produced; no alu_begin after release until a new command.

Configuration
REQ-035 Macro ALU_SEQ_TIMEOUT_EN defined: counter clears on WAIT_END entry, increments each WAIT_END cycle with alu_end=0; on reaching TIMEOUT_CYCLES -> RESP with res_err=1, res_data=16'hFFFF, skipping CAPT_LO.
REQ-036 Macro undefined: no counter logic, WAIT_END waits indefinitely, res_err tied to 0.

Verification
REQ-037 Add: cmd op=00, X=16'h0012, Y=8'h34 -> alu_begin one pulse, inbus 12 then 34; alu_end with outbus 46 then 00 -> res_data=16'h4600, res_err=0.
REQ-038 Div: op=11, X=16'h1234, Y=8'h56 -> inbus 12,34,56 on LOAD0/1/2; alu_end, outbus 0A then 36 -> res_data=16'h0A36.
REQ-039 Backpressure: hold res_ready=0 10 cycles -> res_valid and res_data stable, cmd_ready=0, second cmd_valid ignored; res_ready=1 -> IDLE next cycle.
REQ-040 Reset in WAIT_END -> all outputs to reset values within same cycle; later alu_end pulse produces no res_valid.
REQ-041 With ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, alu_end never asserted -> res_valid after 8 WAIT_END cycles, res_err=1, res_data=16'hFFFF.
REQ-042 Spurious alu_end during LOAD1 -> ignored; state sequence and latency unchanged.
